// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump sequencer: FSM state
// encoding and default geometry, also used by the test harness and debug UART.
package regfile_dump_ctrl_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_READ   = 3'd2,
        ST_OUT    = 3'd3,
        ST_DONE   = 3'd4
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer. Borrows regfile read port A from the CPU,
// stalls the CPU, and streams r0..r(NUM_REGS-1) out over a valid/ready
// channel one word per READ/OUT pair, then hands the port back.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cpu_rs1,
    output logic [ADDR_W-1:0] rf_rs1,
    input  logic [DATA_W-1:0] rf_dataA,
    output logic              cpu_stall,
    output logic              busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;

    logic accept;
    assign accept = dump_valid_q && dump_ready;

    // State and datapath registers; reset abandons any dump in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
        end
    end

    // Next-state: one settle cycle, then alternate READ/OUT until the last word is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FREEZE;
            ST_FREEZE: state_d = ST_READ;
            ST_READ:   state_d = ST_OUT;
            ST_OUT:    if (accept) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Index counter and capture register; the word is latched once and held until accepted.
    always_comb begin
        idx_d        = idx_q;
        dump_valid_d = dump_valid_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) idx_d = '0;
            end
            ST_READ: begin
                dump_data_d  = rf_dataA;
                dump_idx_d   = idx_q;
                dump_valid_d = 1'b1;
            end
            ST_OUT: begin
                if (accept) begin
                    dump_valid_d = 1'b0;
                    // Saturate on the last register so the index never wraps mid-dump.
                    if (idx_q != LAST_IDX) idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: port ownership mux and stall/busy/done decoded from state.
    always_comb begin
        rf_rs1    = cpu_rs1;
        cpu_stall = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_FREEZE: cpu_stall = 1'b1;
            ST_READ: begin
                cpu_stall = 1'b1;
                rf_rs1    = idx_q;
            end
            ST_OUT: begin
                cpu_stall = 1'b1;
                rf_rs1    = idx_q;
            end
            ST_DONE: begin
                cpu_stall = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = cpu_stall;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: a regfile preloaded with rK=3K, directed scenarios,
// and a transaction-level monitor checking stream order, hold behaviour,
// stall duration and port ownership on every cycle.
module tb_regfile_dump_ctrl;
    import regfile_dump_ctrl_pkg::*;

    localparam int NR = DEF_NUM_REGS;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    logic          clock = 1'b0;
    logic          reset, start, dump_ready;
    logic [AW-1:0] cpu_rs1, rf_rs1, dump_idx;
    logic [DW-1:0] rf_dataA, dump_data;
    logic          cpu_stall, busy, dump_valid, done;

    logic [DW-1:0] rf [NR];
    assign rf_dataA = rf[rf_rs1];

    always #5 clock = ~clock;

    regfile_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .cpu_rs1(cpu_rs1),
        .rf_rs1(rf_rs1), .rf_dataA(rf_dataA), .cpu_stall(cpu_stall), .busy(busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .done(done)
    );

    int checks_m = 0, errors_m = 0;
    int checks_d = 0, errors_d = 0;

    task automatic chk_m(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks_m++;
        if (!ok) begin
            errors_m++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_d(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks_d++;
        if (!ok) begin
            errors_d++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    int  done_count = 0;
    int  last_idx   = -1;
    int  last_data  = -1;

    initial begin : monitor
        bit prev_stall = 0, prev_idle_start = 0, prev_hold = 0, prev_acc_last = 0;
        bit in_run = 0, first_seen = 0, done_seen = 0;
        int run_len = 0, holds = 0, exp_k = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk_m({cpu_stall, busy, dump_valid, done} == 4'b0, "reset_ctrl", 64'({cpu_stall, busy, dump_valid, done}), 0);
                chk_m(dump_idx == '0 && dump_data == '0, "reset_data", 64'(dump_data), 0);
                chk_m(rf_rs1 == cpu_rs1, "reset_passthru", 64'(rf_rs1), 64'(cpu_rs1));
                in_run = 0; prev_stall = 0; prev_idle_start = 0; prev_hold = 0; prev_acc_last = 0;
            end else begin
                chk_m(busy == cpu_stall, "busy_eq_stall", 64'(busy), 64'(cpu_stall));
                if (prev_idle_start)
                    chk_m(cpu_stall == 1'b1, "start_begins_dump", 64'(cpu_stall), 1);
                else if (!prev_stall)
                    chk_m(cpu_stall == 1'b0, "idle_stays_idle", 64'(cpu_stall), 0);
                if (cpu_stall && !prev_stall) begin
                    in_run = 1; run_len = 0; holds = 0; exp_k = 0; first_seen = 0; done_seen = 0;
                end
                if (cpu_stall) run_len++;
                if (prev_hold)
                    chk_m(dump_valid == 1'b1, "valid_held_until_accept", 64'(dump_valid), 1);
                if (dump_valid) begin
                    chk_m(cpu_stall == 1'b1, "valid_implies_stall", 64'(cpu_stall), 1);
                    if (!first_seen) begin
                        chk_m(run_len == 3, "first_valid_latency", 64'(run_len), 3);
                        first_seen = 1;
                    end
                    chk_m(dump_idx == AW'(exp_k), "word_idx", 64'(dump_idx), 64'(exp_k));
                    chk_m(dump_data == DW'(exp_k * 3), "word_data", 64'(dump_data), 64'(exp_k * 3));
                    chk_m(rf_rs1 == dump_idx, "port_owned_by_dump", 64'(rf_rs1), 64'(dump_idx));
                end else if (!cpu_stall) begin
                    chk_m(rf_rs1 == cpu_rs1, "port_owned_by_cpu", 64'(rf_rs1), 64'(cpu_rs1));
                end
                if (done || prev_acc_last)
                    chk_m(done == prev_acc_last, "done_after_last_word", 64'(done), 64'(prev_acc_last));
                if (done) begin
                    chk_m(!done_seen && cpu_stall, "done_once_while_stalled", 64'(done_seen), 0);
                    done_seen = 1;
                    done_count++;
                end
                prev_acc_last = dump_valid && dump_ready && (dump_idx == AW'(NR - 1));
                prev_hold     = dump_valid && !dump_ready;
                if (prev_hold) holds++;
                if (dump_valid && dump_ready) begin
                    last_idx  = int'(dump_idx);
                    last_data = int'(dump_data);
                    exp_k++;
                end
                if (!cpu_stall && prev_stall && in_run) begin
                    chk_m(run_len == 2 * NR + 2 + holds, "stall_length", 64'(run_len), 64'(2 * NR + 2 + holds));
                    chk_m(done_seen && exp_k == NR, "all_words_then_done", 64'(exp_k), 64'(NR));
                    in_run = 0;
                end
                prev_stall      = cpu_stall;
                prev_idle_start = !cpu_stall && start;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    bit         ready_pat_mode = 0;
    logic [3:0] ready_pat = 4'b1001;
    int         cyc = 0;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        dump_ready = ready_pat_mode ? ready_pat[cyc % 4] : 1'b1;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int n = 0;
        while (cpu_stall && n < bound) begin
            step();
            n++;
        end
        chk_d(!cpu_stall, nm, 64'(n), 64'(bound));
    endtask

    task automatic wait_word(input int k, input string nm);
        int n = 0;
        while (!(dump_valid && dump_idx == AW'(k)) && n < 200) begin
            step();
            n++;
        end
        chk_d(dump_valid && dump_idx == AW'(k), nm, 64'(dump_idx), 64'(k));
    endtask

    initial begin : stim
        int n, d0;
        for (int k = 0; k < NR; k++) rf[k] = DW'(k * 3);
        reset = 1'b1; start = 1'b0; dump_ready = 1'b1; cpu_rs1 = '0;
        repeat (3) step();
        chk_d({cpu_stall, busy, dump_valid, done} == 4'b0 && dump_data == '0, "reset_state", 64'(dump_data), 0);
        reset = 1'b0;
        step();

        // idle sweep: port passes through, no stall
        for (int k = 0; k < NR; k++) begin
            cpu_rs1 = AW'(k);
            step();
            chk_d(rf_rs1 == AW'(k) && !cpu_stall && !busy, "idle_sweep", 64'(rf_rs1), 64'(k));
        end

        // single dump, ready high
        d0 = done_count;
        start = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) start = 1'b0;
        end while (!dump_valid && n < 10);
        chk_d(n == 3, "start_to_first_valid_edges", 64'(n), 3);
        chk_d(dump_idx == '0 && dump_data == '0, "first_word_r0", 64'(dump_data), 0);
        while (!done && n < 100) begin
            step();
            n++;
        end
        chk_d(n == 66, "start_to_done_edges", 64'(n), 66);
        step();
        chk_d(!cpu_stall, "stall_drops_after_done", 64'(cpu_stall), 0);
        chk_d(done_count - d0 == 1, "dump1_done_count", 64'(done_count - d0), 1);
        chk_d(last_idx == 31 && last_data == 93, "last_word_r31", 64'(last_data), 93);

        // ready toggling 1-0-0-1
        d0 = done_count;
        ready_pat_mode = 1;
        start = 1'b1; step(); start = 1'b0;
        wait_idle(1000, "dump2_finishes");
        chk_d(done_count - d0 == 1, "dump2_done_count", 64'(done_count - d0), 1);
        chk_d(last_idx == 31 && last_data == 93, "dump2_last_word", 64'(last_data), 93);
        ready_pat_mode = 0;
        step();

        // start re-pulsed mid-dump is ignored
        d0 = done_count;
        start = 1'b1; step(); start = 1'b0;
        wait_word(10, "reach_idx10");
        start = 1'b1; step(); start = 1'b0;
        wait_idle(200, "dump3_finishes");
        chk_d(done_count - d0 == 1, "restart_ignored_single_done", 64'(done_count - d0), 1);
        step();

        // start held for 200 cycles: three back-to-back dumps
        d0 = done_count;
        start = 1'b1;
        repeat (200) step();
        start = 1'b0;
        wait_idle(300, "held_start_finishes");
        step();
        chk_d(done_count - d0 == 3, "held_start_dumps", 64'(done_count - d0), 3);
        chk_d(!cpu_stall, "held_start_released", 64'(cpu_stall), 0);

        // reset mid-OUT at idx 7
        d0 = done_count;
        start = 1'b1; step(); start = 1'b0;
        wait_word(7, "reach_idx7");
        dump_ready = 1'b0;
        cpu_rs1 = AW'(5);
        #2 reset = 1'b1;
        #1;
        chk_d({cpu_stall, busy, dump_valid, done} == 4'b0, "async_reset_ctrl", 64'({cpu_stall, busy, dump_valid, done}), 0);
        chk_d(dump_idx == '0 && dump_data == '0, "async_reset_data", 64'(dump_idx), 0);
        chk_d(rf_rs1 == AW'(5), "async_reset_passthru", 64'(rf_rs1), 5);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk_d(!cpu_stall && !dump_valid && done_count == d0, "abandoned_dump", 64'(done_count - d0), 0);

        $display("CHECKS %0d ERRORS %0d", checks_m + checks_d, errors_m + errors_d);
        $finish;
    end

endmodule
